// File: rtl/xil_bram_sdp_1clk_banked_pkg.sv
// Shared types and elaboration-time helpers for the banked single-clock SDP RAM.
package xil_bram_sdp_1clk_banked_pkg;

  localparam int unsigned MaxBanks = 8;

  typedef enum logic {StClr, StRun} clr_st_e;

  // Where the stage-1 read result comes from; SrcZero also covers reset and out-of-range.
  typedef enum logic [1:0] {SrcZero, SrcBank, SrcByp} rd_src_e;

  function automatic int unsigned bank_depth(int unsigned badr);
    return 32'd1 << badr;
  endfunction

  function automatic int unsigned nbank(int unsigned dep, int unsigned badr);
    return (dep + bank_depth(badr) - 1) >> badr;
  endfunction

  function automatic bit cfg_ok(int unsigned adr, int unsigned dep, int unsigned badr,
                                int unsigned del, int unsigned byp_en, int unsigned clr_en);
    return (del == 1 || del == 2) && (byp_en <= 1) && (clr_en <= 1) && (badr <= adr) &&
           (dep >= 1) && (nbank(dep, badr) <= MaxBanks) && (dep <= (32'd1 << adr));
  endfunction

endpackage

// File: rtl/xil_bram_sdp_bank.sv
// One inferred 2^BADR x DAT block RAM bank: read-first, registered read, array not reset.
module xil_bram_sdp_bank
  import xil_bram_sdp_1clk_banked_pkg::*;
#(
  parameter int unsigned BADR = 10,
  parameter int unsigned DAT  = 18
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [BADR-1:0] wa_i,
  input  logic [DAT-1:0]  wd_i,
  input  logic            re_i,
  input  logic [BADR-1:0] ra_i,
  output logic [DAT-1:0]  rd_o
);

  localparam int unsigned Depth = bank_depth(BADR);

  logic [DAT-1:0] mem_q [Depth];
  logic [DAT-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/xil_bram_sdp_1clk_banked.sv
// Banked single-clock SDP RAM with zero-clear sequencer, optional write-first bypass,
// out-of-range flags and 1- or 2-cycle read latency.
module xil_bram_sdp_1clk_banked
  import xil_bram_sdp_1clk_banked_pkg::*;
#(
  parameter int unsigned ADR    = 12,
  parameter int unsigned DAT    = 18,
  parameter int unsigned DEP    = 3072,
  parameter int unsigned BADR   = 10,
  parameter int unsigned DEL    = 1,
  parameter int unsigned BYP_EN = 1,
  parameter int unsigned CLR_EN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           wen,
  input  logic [ADR-1:0] wad,
  input  logic [DAT-1:0] wda,
  input  logic           ren,
  input  logic [ADR-1:0] rad,
  output logic [DAT-1:0] rda,
  output logic           rvld,
  output logic           rerr,
  output logic           werr,
  output logic           busy
);

  localparam int unsigned NBANK = nbank(DEP, BADR);
  localparam logic [BADR-1:0] CntMax = '1;

  if (!cfg_ok(ADR, DEP, BADR, DEL, BYP_EN, CLR_EN)) begin : g_cfg_err
    $error("xil_bram_sdp_1clk_banked: illegal parameter combination");
  end

  clr_st_e st_q, st_d;
  logic [BADR-1:0] cnt_q, cnt_d;

  logic wacc, racc, w_in, r_in, coll;
  logic [2:0] wbank, rbank;

  assign busy  = (st_q == StClr);
  assign wacc  = wen & ~busy;
  assign racc  = ren & ~busy;
  assign w_in  = 32'(wad) < DEP;
  assign r_in  = 32'(rad) < DEP;
  assign wbank = 3'(wad >> BADR);
  assign rbank = 3'(rad >> BADR);
  assign coll  = wacc & racc & w_in & r_in & (wad == rad);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      StClr: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
          st_d  = StRun;
          cnt_d = '0;
        end
      end
      StRun:   if (CLR_EN != 0 && clr) st_d = StClr;
      default: st_d = StRun;
    endcase
    if (CLR_EN == 0) st_d = StRun;
  end

  // Stage-1 read bookkeeping: source select, bank select and the bypassed write word.
  rd_src_e        src_q, src_d;
  logic [2:0]     rsel_q, rsel_d;
  logic [DAT-1:0] byp_q, byp_d;
  logic           vld1_q, vld1_d, err1_q, err1_d, werr_q, werr_d;

  always_comb begin
    src_d  = src_q;
    rsel_d = rsel_q;
    byp_d  = byp_q;
    vld1_d = racc;
    err1_d = racc & ~r_in;
    werr_d = wacc & ~w_in;
    if (racc) begin
      if (!r_in) begin
        src_d = SrcZero;
      end else if (coll && BYP_EN != 0) begin
        src_d = SrcByp;
        byp_d = wda;
      end else begin
        src_d  = SrcBank;
        rsel_d = rbank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= (CLR_EN != 0) ? StClr : StRun;
      cnt_q  <= '0;
      src_q  <= SrcZero;
      rsel_q <= '0;
      byp_q  <= '0;
      vld1_q <= 1'b0;
      err1_q <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      src_q  <= src_d;
      rsel_q <= rsel_d;
      byp_q  <= byp_d;
      vld1_q <= vld1_d;
      err1_q <= err1_d;
      werr_q <= werr_d;
    end
  end

  assign werr = werr_q;

  logic [DAT-1:0]  bank_rd [MaxBanks];
  logic [BADR-1:0] bank_wa;
  logic [DAT-1:0]  bank_wd;

  // While clearing, every bank is written with zero at the sequencer offset.
  assign bank_wa = busy ? cnt_q : wad[BADR-1:0];
  assign bank_wd = busy ? '0 : wda;

  for (genvar b = 0; b < MaxBanks; b++) begin : g_bank
    if (b < NBANK) begin : g_inst
      logic we, re;
      assign we = busy | (wacc & w_in & (wbank == 3'(b)));
      assign re = racc & r_in & (rbank == 3'(b));
      xil_bram_sdp_bank #(
        .BADR (BADR),
        .DAT  (DAT)
      ) u_bank (
        .clk_i (clk),
        .we_i  (we),
        .wa_i  (bank_wa),
        .wd_i  (bank_wd),
        .re_i  (re),
        .ra_i  (rad[BADR-1:0]),
        .rd_o  (bank_rd[b])
      );
    end else begin : g_none
      assign bank_rd[b] = '0;
    end
  end

  logic [DAT-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (src_q)
      SrcBank: rd_mux = bank_rd[rsel_q];
      SrcByp:  rd_mux = byp_q;
      default: rd_mux = '0;
    endcase
  end

  if (DEL == 2) begin : g_del2
    logic [DAT-1:0] rda_q;
    logic           rvld_q, rerr_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rda_q  <= '0;
        rvld_q <= 1'b0;
        rerr_q <= 1'b0;
      end else begin
        rda_q  <= rd_mux;
        rvld_q <= vld1_q;
        rerr_q <= err1_q;
      end
    end
    assign rda  = rda_q;
    assign rvld = rvld_q;
    assign rerr = rerr_q;
  end else begin : g_del1
    assign rda  = rd_mux;
    assign rvld = vld1_q;
    assign rerr = err1_q;
  end

endmodule

// File: tb/tb_xil_bram_sdp_1clk_banked.sv
// Bench for xil_bram_sdp_1clk_banked: three configurations share one stimulus stream.
module tb_xil_bram_sdp_1clk_banked;

  localparam int unsigned ADR   = 6;
  localparam int unsigned DAT   = 18;
  localparam int unsigned DEP   = 40;
  localparam int unsigned BADR  = 4;
  localparam int          NWORD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clr, wen, ren;
  logic [ADR-1:0] wad, rad;
  logic [DAT-1:0] wda;

  logic [DAT-1:0] rda_a, rda_b, rda_c;
  logic rvld_a, rerr_a, werr_a, busy_a;
  logic rvld_b, rerr_b, werr_b, busy_b;
  logic rvld_c, rerr_c, werr_c, busy_c;

  // A: DEL=1 write-first; B: DEL=2 read-first; C: no clear sequencer.
  xil_bram_sdp_1clk_banked #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .BADR(BADR), .DEL(1),
    .BYP_EN(1), .CLR_EN(1)) u_a (.clk(clk), .rst(rst), .clr(clr), .wen(wen), .wad(wad),
    .wda(wda), .ren(ren), .rad(rad), .rda(rda_a), .rvld(rvld_a), .rerr(rerr_a),
    .werr(werr_a), .busy(busy_a));

  xil_bram_sdp_1clk_banked #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .BADR(BADR), .DEL(2),
    .BYP_EN(0), .CLR_EN(1)) u_b (.clk(clk), .rst(rst), .clr(clr), .wen(wen), .wad(wad),
    .wda(wda), .ren(ren), .rad(rad), .rda(rda_b), .rvld(rvld_b), .rerr(rerr_b),
    .werr(werr_b), .busy(busy_b));

  xil_bram_sdp_1clk_banked #(.ADR(ADR), .DAT(DAT), .DEP(DEP), .BADR(BADR), .DEL(1),
    .BYP_EN(1), .CLR_EN(0)) u_c (.clk(clk), .rst(rst), .clr(clr), .wen(wen), .wad(wad),
    .wda(wda), .ren(ren), .rad(rad), .rda(rda_c), .rvld(rvld_c), .rerr(rerr_c),
    .werr(werr_c), .busy(busy_c));

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [DAT-1:0] mem [DEP];
  int             busy_left;
  logic [DAT-1:0] last_a, last_b;
  logic           ea_v, ea_e, sb_v, sb_e, eb_v, eb_e, ew, ec_v, ec_e, ec_w;
  logic [DAT-1:0] ea_d, sb_d, eb_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_left = NWORD;
    last_a = '0; last_b = '0;
    ea_v = 0; ea_e = 0; ea_d = '0;
    sb_v = 0; sb_e = 0; sb_d = '0;
    eb_v = 0; eb_e = 0; eb_d = '0;
    ew = 0; ec_v = 0; ec_e = 0; ec_w = 0;
  endtask

  task automatic model_edge();
    bit acc, rv, re, wv, coll;
    int ri, wi;
    logic [DAT-1:0] ra, rb;
    ri = int'(rad);
    wi = int'(wad);
    acc  = (busy_left == 0);
    rv   = acc && ren;
    re   = rv && (ri >= DEP);
    wv   = acc && wen && (wi < DEP);
    coll = rv && !re && wv && (wi == ri);
    ra = '0; rb = '0;
    if (rv && !re) begin
      rb = mem[ri];
      ra = coll ? wda : mem[ri];
    end
    if (rv) begin
      last_a = ra;
      last_b = rb;
    end
    ea_v = rv; ea_d = last_a; ea_e = re;
    eb_v = sb_v; eb_d = sb_d; eb_e = sb_e;
    sb_v = rv; sb_d = last_b; sb_e = re;
    ew   = acc && wen && (wi >= DEP);
    ec_v = ren; ec_e = ren && (ri >= DEP); ec_w = wen && (wi >= DEP);
    if (wv) mem[wi] = wda;
    if (busy_left > 0) begin
      busy_left--;
      foreach (mem[i]) mem[i] = '0;
    end else if (clr) begin
      busy_left = NWORD;
    end
  endtask

  task automatic check_all();
    chk("a_rvld", 32'(rvld_a), 32'(ea_v));
    chk("a_rda",  32'(rda_a),  32'(ea_d));
    chk("a_rerr", 32'(rerr_a), 32'(ea_e));
    chk("a_werr", 32'(werr_a), 32'(ew));
    chk("a_busy", 32'(busy_a), 32'(busy_left != 0));
    chk("b_rvld", 32'(rvld_b), 32'(eb_v));
    chk("b_rda",  32'(rda_b),  32'(eb_d));
    chk("b_rerr", 32'(rerr_b), 32'(eb_e));
    chk("b_werr", 32'(werr_b), 32'(ew));
    chk("b_busy", 32'(busy_b), 32'(busy_left != 0));
    chk("c_rvld", 32'(rvld_c), 32'(ec_v));
    chk("c_rerr", 32'(rerr_c), 32'(ec_e));
    chk("c_werr", 32'(werr_c), 32'(ec_w));
    chk("c_busy", 32'(busy_c), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a_out"}, {rda_a, rvld_a, rerr_a, werr_a}, 32'd0);
    chk({tag, "_b_out"}, {rda_b, rvld_b, rerr_b, werr_b}, 32'd0);
    chk({tag, "_c_out"}, {rda_c, rvld_c, rerr_c, werr_c}, 32'd0);
    chk({tag, "_busy"}, {busy_a, busy_b, busy_c}, 32'b110);
  endtask

  task automatic step(input bit w, input int wa, input logic [DAT-1:0] wd,
                      input bit r, input int ra, input bit c);
    wen = w; wad = ADR'(wa); wda = wd; ren = r; rad = ADR'(ra); clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_step(input bit allow_clr);
    int wa, ra;
    wa = int'($urandom_range(0, 47));
    ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 47));
    step(1'($urandom_range(0, 1)), wa, DAT'($urandom), 1'($urandom_range(0, 1)), ra,
         allow_clr && ($urandom_range(0, 59) == 0));
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    step(0, 0, '0, 1, a, 0);
  endtask

  task automatic wr(input int a, input logic [DAT-1:0] d);
    step(1, a, d, 0, 0, 0);
  endtask

  // Counts busy cycles under random traffic, which must all be dropped.
  task automatic busy_run(input string tag);
    int n = 0;
    while (busy_a && n < 40) begin
      rand_step(0);
      n++;
    end
    chk(tag, 32'(n), 32'(NWORD));
  endtask

  initial begin
    rst = 1'b0; clr = 0; wen = 0; ren = 0; wad = '0; rad = '0; wda = '0;
    foreach (mem[i]) mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b1;
    model_reset();

    busy_run("clr_len_por");
    for (int a = 0; a < 48; a++) rd(a);
    idle(); idle();

    wr(37, 18'h2A5A3);
    rd(37);
    idle(); idle();

    wr(5, 18'h11);
    step(1, 5, 18'h22, 1, 5, 0);
    rd(5);
    idle(); idle();

    wr(45, 18'h3ABCD);
    rd(45);
    idle();
    for (int a = 0; a < 40; a++) rd(a);
    idle(); idle();

    rd(37);
    step(0, 0, '0, 1, 5, 1);
    busy_run("clr_len_req");
    for (int a = 0; a < 40; a++) rd(a);
    idle(); idle();

    for (int i = 0; i < 400; i++) rand_step(1);
    while (busy_left > 0) idle();

    for (int i = 0; i < 60; i++) rand_step(0);
    step(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 7; i++) rand_step(0);
    rst = 1'b0;
    model_reset();
    #1;
    check_reset("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_hold");
    rst = 1'b1;
    busy_run("clr_len_rst");
    for (int a = 0; a < 40; a++) rd(a);
    for (int i = 0; i < 100; i++) rand_step(0);
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
